instr_fetch_ctrl: RTL and testbench

Sequences the single-port, combinationally read instruction memory for the CPU core. It owns the fetch PC and drives the memory address, and it buffers fetched words with their PCs in a small FIFO. The buffered words go to decode over a valid/ready handshake. It handles start, branch/jump redirects with flush, and out-of-range or misaligned fetch faults.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/instr_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_pkg;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_FETCH,
      FS_STALL,
      FS_FAULT
   } fetch_state_t;

   localparam int WORD_BYTES   = 4;
   localparam int ENTRY_ADDR_W = 32;
   localparam int ENTRY_DATA_W = 32;

   // Widest supported entry; narrower ADDR_W/DATA_W configurations zero-extend into it.
   typedef struct packed {
      logic [ENTRY_DATA_W-1:0] instr;
      logic [ENTRY_ADDR_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, count and registered head entry
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             pop_fire;
   logic             push_fire;

   assign pop_fire  = pop_i && (count_q != '0);
   assign push_fire = push_i && ((count_q < CNT_W'(DEPTH)) || pop_fire);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            store[i] <= '0;
         end
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_fire) begin
            store[wr_ptr] <= wdata_i;
            wr_ptr        <= wr_ptr + PTR_W'(1);
         end
         if (pop_fire) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
      end
   end

   assign rdata_o = store[rd_ptr];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - fetch PC sequencer feeding decode through a small fetch buffer
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                FIFO_DEPTH = 2,
   parameter int                MEM_WORDS  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_instr_i,
   output logic [DATA_W-1:0] instr_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              busy_o,
   output logic              fault_o
);

   localparam int              CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_W:0] PC_LIMIT = (ADDR_W + 1)'(MEM_WORDS * WORD_BYTES);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] pc_nxt;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;
   logic              flush;
   logic              slot_free;
   logic              in_range;
   logic              misaligned;
   fetch_entry_t      push_entry;
   fetch_entry_t      head_entry;

   assign pop        = valid_o && ready_i;
   assign slot_free  = (count < CNT_W'(FIFO_DEPTH)) || pop;
   assign in_range   = ({1'b0, fetch_pc} < PC_LIMIT);
   assign misaligned = (redirect_pc_i[1:0] != 2'b00);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= FS_IDLE;
         fetch_pc <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= pc_nxt;
      end
   end

   // Redirect overrides every state; the flush also swallows any same-cycle push/pop.
   always_comb begin
      state_nxt = state;
      pc_nxt    = fetch_pc;
      push      = 1'b0;
      flush     = 1'b0;
      if (redirect_i) begin
         flush  = 1'b1;
         pc_nxt = {redirect_pc_i[ADDR_W-1:2], 2'b00};
         if (misaligned) begin
            state_nxt = FS_FAULT;
         end else if (state == FS_IDLE) begin
            state_nxt = FS_IDLE;
         end else begin
            state_nxt = FS_FETCH;
         end
      end else begin
         case (state)
            FS_IDLE: begin
               if (start_i) begin
                  state_nxt = FS_FETCH;
               end
            end
            FS_FETCH: begin
               if (!in_range) begin
                  state_nxt = FS_FAULT;
               end else if (slot_free) begin
                  push   = 1'b1;
                  pc_nxt = fetch_pc + ADDR_W'(WORD_BYTES);
               end else begin
                  state_nxt = FS_STALL;
               end
            end
            FS_STALL: begin
               if (!in_range) begin
                  state_nxt = FS_FAULT;
               end else if (pop) begin
                  state_nxt = FS_FETCH;
               end
            end
            FS_FAULT: begin
               state_nxt = FS_FAULT;
            end
            default: begin
               state_nxt = FS_IDLE;
            end
         endcase
      end
   end

   assign push_entry.instr = ENTRY_DATA_W'(mem_instr_i);
   assign push_entry.pc    = ENTRY_ADDR_W'(fetch_pc);

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush),
      .push_i  (push),
      .wdata_i (push_entry),
      .pop_i   (pop),
      .rdata_o (head_entry),
      .valid_o (valid_o),
      .count_o (count)
   );

   assign mem_addr_o = fetch_pc;
   assign instr_o    = head_entry.instr[DATA_W-1:0];
   assign pc_o       = head_entry.pc[ADDR_W-1:0];
   assign busy_o     = (state == FS_FETCH) || (state == FS_STALL);
   assign fault_o    = (state == FS_FAULT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - self-checking bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] mem [64];

   logic        start_a, redir_a, ready_a;
   logic [31:0] redir_pc_a, addr_a, mem_a, instr_a, pc_a;
   logic        valid_a, busy_a, fault_a;

   logic        start_b, redir_b, ready_b;
   logic [31:0] redir_pc_b, addr_b, mem_b, instr_b, pc_b;
   logic        valid_b, busy_b, fault_b;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   always_comb mem_a = (addr_a < 32'd256) ? mem[addr_a[7:2]] : 32'hDEAD_BEEF;
   always_comb mem_b = (addr_b < 32'd256) ? mem[addr_b[7:2]] : 32'hDEAD_BEEF;

   instr_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2), .MEM_WORDS(32), .RESET_PC(32'h0)) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start_a), .redirect_i(redir_a),
      .redirect_pc_i(redir_pc_a), .mem_addr_o(addr_a), .mem_instr_i(mem_a),
      .instr_o(instr_a), .pc_o(pc_a), .valid_o(valid_a), .ready_i(ready_a),
      .busy_o(busy_a), .fault_o(fault_a)
   );

   instr_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2), .MEM_WORDS(4), .RESET_PC(32'h0)) dut_small (
      .clk_i(clk), .rst_i(rst_n), .start_i(start_b), .redirect_i(redir_b),
      .redirect_pc_i(redir_pc_b), .mem_addr_o(addr_b), .mem_instr_i(mem_b),
      .instr_o(instr_b), .pc_o(pc_b), .valid_o(valid_b), .ready_i(ready_b),
      .busy_o(busy_b), .fault_o(fault_b)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      start_a = 0; redir_a = 0; ready_a = 0; redir_pc_a = 0;
      start_b = 0; redir_b = 0; ready_b = 0; redir_pc_b = 0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      start_a = 1; ready_a = 1;
      step(); start_a = 0;
      step();
      rst_n = 1'b0;
      #1;
      vectors++;
      if (addr_a !== 32'h0 || valid_a !== 1'b0 || instr_a !== 32'h0 || pc_a !== 32'h0 ||
          busy_a !== 1'b0 || fault_a !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: addr=%h valid=%b instr=%h pc=%h busy=%b fault=%b expected all zero",
                  addr_a, valid_a, instr_a, pc_a, busy_a, fault_a);
      end
      vectors++;
      if (valid_b !== 1'b0 || fault_b !== 1'b0 || addr_b !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_small: valid=%b fault=%b addr=%h expected 0/0/0", valid_b, fault_b, addr_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_start_stream();
      do_reset();
      ready_a = 1; start_a = 1;
      step(); start_a = 0;
      vectors++;
      if (valid_a !== 1'b0 || busy_a !== 1'b1) begin
         miscompares++;
         $display("FAIL start_latency: valid=%b busy=%b expected valid 0 busy 1", valid_a, busy_a);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         vectors++;
         if (valid_a !== 1'b1 || pc_a !== 32'(k * 4) || instr_a !== 32'(32'h11 * (k + 1))) begin
            miscompares++;
            $display("FAIL start_stream[%0d]: valid=%b pc=%h instr=%h expected 1 %h %h",
                     k, valid_a, pc_a, instr_a, k * 4, 32'h11 * (k + 1));
         end
      end
   endtask

   task automatic test_backpressure();
      int got;
      do_reset();
      ready_a = 0; start_a = 1;
      step(); start_a = 0;
      step();
      vectors++;
      if (valid_a !== 1'b1 || pc_a !== 32'h0) begin
         miscompares++;
         $display("FAIL bp_first: valid=%b pc=%h expected 1 0", valid_a, pc_a);
      end
      for (int c = 1; c < 5; c++) begin
         step();
         vectors++;
         if (valid_a !== 1'b1 || pc_a !== 32'h0 || instr_a !== 32'h11 || addr_a !== 32'h8 || busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: valid=%b pc=%h instr=%h addr=%h busy=%b expected 1 0 11 8 1",
                     c, valid_a, pc_a, instr_a, addr_a, busy_a);
         end
      end
      ready_a = 1;
      got = 0;
      for (int t = 0; t < 14 && got < 6; t++) begin
         if (valid_a) begin
            vectors++;
            if (pc_a !== 32'(got * 4) || instr_a !== mem[got]) begin
               miscompares++;
               $display("FAIL bp_release[%0d]: pc=%h instr=%h expected %h %h", got, pc_a, instr_a, got * 4, mem[got]);
            end
            got++;
         end
         step();
      end
      vectors++;
      if (got != 6) begin
         miscompares++;
         $display("FAIL bp_release_count: got %0d transfers expected 6", got);
      end
   endtask

   task automatic test_redirect_full();
      int got;
      do_reset();
      ready_a = 0; start_a = 1;
      step(); start_a = 0;
      step(); step();
      redir_a = 1; redir_pc_a = 32'h40; ready_a = 1;
      step(); redir_a = 0;
      vectors++;
      if (valid_a !== 1'b0 || addr_a !== 32'h40 || fault_a !== 1'b0) begin
         miscompares++;
         $display("FAIL redir_flush: valid=%b addr=%h fault=%b expected 0 40 0", valid_a, addr_a, fault_a);
      end
      step();
      got = 0;
      for (int t = 0; t < 10 && got < 4; t++) begin
         if (valid_a) begin
            vectors++;
            if (pc_a !== 32'(32'h40 + got * 4) || instr_a !== mem[16 + got]) begin
               miscompares++;
               $display("FAIL redir_stream[%0d]: pc=%h instr=%h expected %h %h",
                        got, pc_a, instr_a, 32'h40 + got * 4, mem[16 + got]);
            end
            got++;
         end
         step();
      end
      vectors++;
      if (got != 4) begin
         miscompares++;
         $display("FAIL redir_count: got %0d transfers expected 4", got);
      end
   endtask

   task automatic test_range_fault();
      int got;
      do_reset();
      ready_b = 1; start_b = 1;
      step(); start_b = 0;
      got = 0;
      for (int c = 1; c <= 7; c++) begin
         if (valid_b) begin
            vectors++;
            if (got >= 4 || pc_b !== 32'(got * 4) || instr_b !== mem[got]) begin
               miscompares++;
               $display("FAIL range_stream[%0d]: pc=%h instr=%h expected pc %h below 10", got, pc_b, instr_b, got * 4);
            end
            got++;
         end
         if (c == 5) begin
            vectors++;
            if (addr_b !== 32'h10 || fault_b !== 1'b0) begin
               miscompares++;
               $display("FAIL range_pre: addr=%h fault=%b expected 10 0", addr_b, fault_b);
            end
         end
         if (c == 6) begin
            vectors++;
            if (fault_b !== 1'b1 || busy_b !== 1'b0) begin
               miscompares++;
               $display("FAIL range_fault: fault=%b busy=%b expected 1 0", fault_b, busy_b);
            end
         end
         step();
      end
      vectors++;
      if (got != 4) begin
         miscompares++;
         $display("FAIL range_count: got %0d transfers expected 4", got);
      end
      redir_b = 1; redir_pc_b = 32'h0;
      step(); redir_b = 0;
      vectors++;
      if (fault_b !== 1'b0 || busy_b !== 1'b1 || addr_b !== 32'h0 || valid_b !== 1'b0) begin
         miscompares++;
         $display("FAIL range_recover: fault=%b busy=%b addr=%h valid=%b expected 0 1 0 0",
                  fault_b, busy_b, addr_b, valid_b);
      end
      step();
      vectors++;
      if (valid_b !== 1'b1 || pc_b !== 32'h0 || instr_b !== mem[0]) begin
         miscompares++;
         $display("FAIL range_resume: valid=%b pc=%h instr=%h expected 1 0 %h", valid_b, pc_b, instr_b, mem[0]);
      end
   endtask

   task automatic test_misaligned();
      do_reset();
      ready_a = 0; start_a = 1;
      step(); start_a = 0;
      step(); step();
      redir_a = 1; redir_pc_a = 32'h06;
      step(); redir_a = 0;
      vectors++;
      if (fault_a !== 1'b1 || valid_a !== 1'b0 || addr_a !== 32'h04) begin
         miscompares++;
         $display("FAIL misaligned: fault=%b valid=%b addr=%h expected 1 0 4", fault_a, valid_a, addr_a);
      end
      step(); step();
      vectors++;
      if (fault_a !== 1'b1 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
         miscompares++;
         $display("FAIL misaligned_hold: fault=%b valid=%b busy=%b expected 1 0 0", fault_a, valid_a, busy_a);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      ready_a = 0; start_a = 1;
      step(); start_a = 0;
      step(); step();
      vectors++;
      if (valid_a !== 1'b1 || addr_a !== 32'h8) begin
         miscompares++;
         $display("FAIL mid_setup: valid=%b addr=%h expected 1 8", valid_a, addr_a);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (valid_a !== 1'b0 || addr_a !== 32'h0 || busy_a !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: valid=%b addr=%h busy=%b expected 0 0 0", valid_a, addr_a, busy_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   // Reference: decode must see one contiguous ascending run per aligned redirect, cut off at the memory limit.
   task automatic test_random();
      logic [31:0] exp_pc, hold_pc, hold_instr, tgt;
      logic        exp_dead, hold_prev, redir_prev;
      int          transfers;
      do_reset();
      ready_a = 1; start_a = 1;
      step(); start_a = 0;
      exp_pc = 0; exp_dead = 0; hold_prev = 0; redir_prev = 0; transfers = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (hold_prev) begin
            vectors++;
            if (valid_a !== 1'b1 || pc_a !== hold_pc || instr_a !== hold_instr) begin
               miscompares++;
               $display("FAIL rnd_stable@%0d: valid=%b pc=%h instr=%h expected 1 %h %h",
                        cyc, valid_a, pc_a, instr_a, hold_pc, hold_instr);
            end
         end
         if (redir_prev) begin
            vectors++;
            if (valid_a !== 1'b0) begin
               miscompares++;
               $display("FAIL rnd_flush@%0d: valid=%b expected 0", cyc, valid_a);
            end
         end
         ready_a = ($urandom_range(0, 3) != 0);
         redir_a = ($urandom_range(0, 23) == 0);
         start_a = ($urandom_range(0, 7) == 0);
         tgt = 32'($urandom_range(0, 31) * 4);
         if ($urandom_range(0, 5) == 0) tgt = tgt + 32'($urandom_range(1, 3));
         redir_pc_a = tgt;
         if (valid_a && ready_a && !redir_a) begin
            vectors++;
            transfers++;
            if (exp_dead || exp_pc >= 32'd128 || pc_a !== exp_pc || instr_a !== mem[exp_pc[7:2]]) begin
               miscompares++;
               $display("FAIL rnd_transfer@%0d: pc=%h instr=%h expected %h %h (dead=%b)",
                        cyc, pc_a, instr_a, exp_pc, mem[exp_pc[7:2]], exp_dead);
            end
            exp_pc = exp_pc + 4;
         end
         hold_prev  = valid_a && !ready_a && !redir_a;
         hold_pc    = pc_a;
         hold_instr = instr_a;
         redir_prev = redir_a;
         if (redir_a) begin
            if (tgt[1:0] != 2'b00) begin
               exp_dead = 1;
            end else begin
               exp_dead = 0;
               exp_pc   = tgt;
            end
         end
         step();
      end
      redir_a = 0; start_a = 0;
      vectors++;
      if (transfers < 100) begin
         miscompares++;
         $display("FAIL rnd_progress: %0d transfers expected at least 100", transfers);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i] = (i < 4) ? 32'(32'h11 * (i + 1)) : $urandom;
      end
      rst_n = 1'b0;
      @(negedge clk);
      test_reset();
      test_start_stream();
      test_backpressure();
      test_redirect_full();
      test_range_fault();
      test_misaligned();
      test_reset_midstream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
